// File: rtl/sw_pkg.sv
// Shared definitions for the packet switch: flit type encoding, field positions
// and default port/flit sizes.
package sw_pkg;

    typedef enum logic [1:0] {
        FT_EMPTY = 2'b00,
        FT_HEAD  = 2'b01,
        FT_BODY  = 2'b10,
        FT_TAIL  = 2'b11
    } flit_type_t;

    localparam logic ASSERT = 1'b1;
    localparam logic NEGATE = 1'b0;

    // Type field occupies the top TYPE_W bits; HEAD destination sits at DST_LSB.
    localparam int TYPE_W  = 2;
    localparam int DST_LSB = 0;

    localparam int DEF_N_PORT = 4;
    localparam int DEF_PKTW   = 10;

endpackage

// File: rtl/rr_arb.sv
// N-way round-robin arbiter: scans from ptr+1 upward (mod N_PORT) and returns a
// one-hot grant for the first active request while en is high.
module rr_arb
    import sw_pkg::*;
#(
    parameter  int N_PORT = DEF_N_PORT,
    localparam int DSTW   = $clog2(N_PORT)
) (
    input  logic [N_PORT-1:0] req,
    input  logic [DSTW-1:0]   ptr,
    input  logic              en,
    output logic [N_PORT-1:0] gnt
);

    logic            found;
    logic [DSTW-1:0] idx;

    // N_PORT is a power of two, so DSTW-bit wrap-around gives the modulo scan.
    always_comb begin
        gnt   = '0;
        found = NEGATE;
        idx   = '0;
        for (int unsigned k = 1; k <= N_PORT; k++) begin
            idx = ptr + DSTW'(k);
            if (en && !found && req[idx]) begin
                gnt[idx] = ASSERT;
                found    = ASSERT;
            end
        end
    end

endmodule

// File: rtl/cb_rr.sv
// Wormhole crossbar: per-output round-robin arbitration with head-to-tail lock
// and a registered, back-pressurable output flit per port.
module cb_rr
    import sw_pkg::*;
#(
    parameter int N_PORT = DEF_N_PORT,
    parameter int PKTW   = DEF_PKTW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PORT*PKTW-1:0] in_pkt,
    output logic [N_PORT-1:0]      in_ack,
    output logic [N_PORT*PKTW-1:0] out_pkt,
    input  logic [N_PORT-1:0]      out_rdy
);

    localparam int DSTW = $clog2(N_PORT);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    logic [PKTW-1:0]   flit  [N_PORT];
    flit_type_t        ftype [N_PORT];
    logic [DSTW-1:0]   fdst  [N_PORT];
    logic [N_PORT-1:0] owns;
    logic [N_PORT-1:0] acc;
    logic [N_PORT-1:0] req   [N_PORT];
    logic [N_PORT-1:0] gnt   [N_PORT];

    logic              st_q    [N_PORT];
    logic              st_d    [N_PORT];
    logic [DSTW-1:0]   owner_q [N_PORT];
    logic [DSTW-1:0]   owner_d [N_PORT];
    logic [DSTW-1:0]   ptr_q   [N_PORT];
    logic [DSTW-1:0]   ptr_d   [N_PORT];
    logic [PKTW-1:0]   opkt_q  [N_PORT];
    logic [PKTW-1:0]   opkt_d  [N_PORT];

    logic [PKTW-1:0]   sel_flit;
    logic [DSTW-1:0]   sel_idx;

    always_comb begin
        owns = '0;
        for (int unsigned i = 0; i < N_PORT; i++) begin
            flit[i]  = in_pkt[i*PKTW +: PKTW];
            ftype[i] = flit_type_t'(flit[i][PKTW-1 -: TYPE_W]);
            fdst[i]  = flit[i][DST_LSB +: DSTW];
        end
        for (int unsigned j = 0; j < N_PORT; j++) begin
            if (st_q[j] == ST_LOCK) owns[owner_q[j]] = ASSERT;
        end
    end

    // A lock-holding input may not open a second packet; non-owners never stream.
    always_comb begin
        for (int unsigned j = 0; j < N_PORT; j++) begin
            req[j] = '0;
            acc[j] = out_rdy[j] | (flit_type_t'(opkt_q[j][PKTW-1 -: TYPE_W]) == FT_EMPTY);
            for (int unsigned i = 0; i < N_PORT; i++) begin
                if (st_q[j] == ST_IDLE)
                    req[j][i] = (ftype[i] == FT_HEAD) && (fdst[i] == DSTW'(j)) && !owns[i];
                else
                    req[j][i] = (owner_q[j] == DSTW'(i)) &&
                                ((ftype[i] == FT_BODY) || (ftype[i] == FT_TAIL));
            end
        end
    end

    for (genvar j = 0; j < N_PORT; j++) begin : g_arb
        rr_arb #(.N_PORT(N_PORT)) u_arb (
            .req (req[j]),
            .ptr (ptr_q[j]),
            .en  (acc[j]),
            .gnt (gnt[j])
        );
        assign out_pkt[j*PKTW +: PKTW] = opkt_q[j];
    end

    always_comb begin
        in_ack = '0;
        for (int unsigned j = 0; j < N_PORT; j++) in_ack = in_ack | gnt[j];
        if (rst) in_ack = '0;
    end

    always_comb begin
        sel_flit = '0;
        sel_idx  = '0;
        for (int unsigned j = 0; j < N_PORT; j++) begin
            st_d[j]    = st_q[j];
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            opkt_d[j]  = opkt_q[j];
            sel_flit   = '0;
            sel_idx    = '0;
            for (int unsigned i = 0; i < N_PORT; i++) begin
                if (gnt[j][i]) begin
                    sel_flit = sel_flit | flit[i];
                    sel_idx  = sel_idx | DSTW'(i);
                end
            end
            if (|gnt[j]) begin
                opkt_d[j] = sel_flit;
                case (flit_type_t'(sel_flit[PKTW-1 -: TYPE_W]))
                    FT_HEAD: begin
                        st_d[j]    = ST_LOCK;
                        owner_d[j] = sel_idx;
                    end
                    FT_TAIL: begin
                        st_d[j]  = ST_IDLE;
                        ptr_d[j] = owner_q[j];
                    end
                    default: ;
                endcase
            end else if (out_rdy[j]) begin
                opkt_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < N_PORT; j++) begin
            if (rst) begin
                st_q[j]    <= ST_IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= DSTW'(N_PORT-1);
                opkt_q[j]  <= '0;
            end else begin
                st_q[j]    <= st_d[j];
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
                opkt_q[j]  <= opkt_d[j];
            end
        end
    end

endmodule

// File: doc/cb_rr.md
Name: cb_rr

Overview:
- Parametrised N-port wormhole crossbar for the packet switch.
- Sits between the input buffers (ib) and the output links.
- Integrates per-output round-robin arbitration with packet lock (head to tail) and a registered, back-pressurable output stage.
- Replaces the separate arbiter-plus-combinational-crossbar pair.

Parameters:
- N_PORT, 4, number of input ports and number of output ports (power of two, 2..16).
- PKTW, 10, flit width in bits (type field plus payload).
- DSTW, $clog2(N_PORT), localparam: destination field width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_pkt  in  N_PORT*PKTW  flit presented by each input buffer; input i occupies slice [i*PKTW +: PKTW].
- in_ack  out  N_PORT  combinational; bit i = input i's flit is consumed this cycle, so the ib pops.
- out_pkt  out  N_PORT*PKTW  registered flit per output port, same slicing.
- out_rdy  in  N_PORT  downstream accepts out_pkt[j] this cycle.

Behaviour:
- Flit format:
  - [PKTW-1:PKTW-2] type: 00 EMPTY, 01 HEAD, 10 BODY, 11 TAIL.
  - For HEAD flits, [DSTW-1:0] is the destination output.
  - A packet is HEAD, zero or more BODY, then TAIL (at least 2 flits).
- Per-output state: st_j in {IDLE, LOCK}, owner_j (DSTW bits), ptr_j (last granted input), out_pkt_j.
- Register acceptance: acc_j = out_rdy[j] OR (out_pkt_j type == EMPTY).
- Requests:
  - In IDLE: input i requests j iff its flit is HEAD with dest == j.
  - In LOCK: only owner_j requests j, iff its flit is BODY or TAIL.
- Grant:
  - In IDLE, when acc_j = 1, choose the first requester scanning ptr_j+1, ptr_j+2, ... modulo N_PORT.
  - In LOCK, the owner wins whenever acc_j = 1.
- Transfer (granted input i to output j) in the same cycle:
  - in_ack[i] = 1.
  - At the next edge, out_pkt_j <= flit.
  - A HEAD moves st_j to LOCK with owner_j <= i.
  - A TAIL moves st_j to IDLE with ptr_j <= owner_j.
- No transfer:
  - If out_rdy[j] = 1, out_pkt_j <= 0 (flit consumed).
  - Otherwise out_pkt_j holds its value.
- Latency: 1 cycle from in_ack to the flit on out_pkt. Throughput is 1 flit/cycle/output when out_rdy stays high.
- Each input targets at most one output per cycle, so in_ack[i] has at most one source and at most one output grants input i.
- Boundary cases:
  - TAIL and a competing HEAD in the same cycle: the TAIL transfers. The HEAD is arbitrated the next cycle with the updated ptr_j.
  - HEADs aimed at a LOCKed output wait with no ack. They do not block other outputs.
  - BODY/TAIL from an input that owns no lock is a protocol error: ignored, no ack, no output. HEAD from an input that already owns a lock gets the same treatment.
  - out_rdy low with the register full: out_pkt_j is held stable, no ack toward j, and the lock is kept.
  - EMPTY flits never request and are never acked.
- Reset (synchronous, active-high; applies mid-packet too):
  - All out_pkt cleared to 0, st_j = IDLE, ptr_j = N_PORT-1 (input 0 has first priority).
  - in_ack forced to 0 while rst is high.
  - Partial packets are discarded.

Decomposition:
- Shared package sw_pkg:
  - flit_type_t enum (EMPTY/HEAD/BODY/TAIL).
  - ASSERT/NEGATE constants.
  - Type-field and destination-field position localparams.
  - Default N_PORT/PKTW.
- One sub-module rr_arb:
  - N-way round-robin arbiter.
  - Inputs: req vector, ptr, en. Output: one-hot gnt.
  - Instantiated once per output.
- The crossbar mux and the lock FSM stay in cb_rr.

Test Plan:
1. Single packet, input 0 to output 2: after reset, in0 drives HEAD 10'b01_00000010, then BODY 10'b10_10101010, then TAIL 10'b11_01010101, out_rdy all 1. Required: in_ack[0] high for 3 consecutive cycles. out_pkt[2] shows the same three flits, each 1 cycle later, then 0. Other outputs stay 0.
2. Contention: after reset, in0, in1 and in3 present HEADs to output 1 simultaneously, each packet being HEAD,BODY,TAIL. Required: packets emerge whole and unmixed in order in0, in1, in3. Each next HEAD is acked the cycle after the previous TAIL. The final ptr_1 equals 3.
3. Backpressure: out_rdy[2] = 0 for 4 cycles mid-packet. Required: out_pkt[2] stays constant and in_ack to the owner is 0. When out_rdy returns high, flow resumes with no drop and no duplicate.
4. Full permutation: in0 to out3, in1 to out2, in2 to out1, in3 to out0, each packet of 4 flits. Required: in_ack = 4'b1111 for 4 cycles, and all outputs carry their streams in parallel at 1-cycle latency.
5. Reset mid-packet: assert rst for 1 cycle after the BODY flit. Required: next cycle all out_pkt = 0 and in_ack = 0 during rst. A fresh HEAD from any input to the same output is then accepted immediately.
6. Protocol error: a BODY flit from an input holding no lock, with no other traffic. Required: in_ack bit stays 0 and out_pkt stays 0 until a HEAD arrives.
